clefia_ks_gfn12: RTL and testbench
==================================

CLEFIA_KS_GFN12 -- requirements
Module: clefia_ks_gfn12

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: start  in  1  request to compute L from key; sampled only in IDLE.
REQ-004 SHALL have ports: key  in  128  secret key K; key[127:96] = T0 ... key[31:0] = T3; sampled with start.
REQ-005 SHALL have ports: Round  out  4  round index driven to the CON constant table; 1..12 while running, 0 otherwise.
REQ-006 SHALL have ports: CON  in  64  constant pair for Round; CON[63:32] = CON_(2i-2), CON[31:0] = CON_(2i-1); consumed combinationally in the same cycle.
REQ-007 SHALL have ports: busy  out  1  high in RUN.
REQ-008 SHALL have ports: done  out  1  one-cycle pulse when L is valid.
REQ-009 SHALL have ports: L  out  128  intermediate key L = GFN4,12(CON0..23, K); held until the next accepted start.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE.
REQ-011 SHALL, in IDLE with start=1, load T0..T3 from key, set Round=1 and enter RUN on the next edge.
REQ-012 SHALL, per RUN cycle with round i, compute T1' = T1 ^ F0(CON[63:32], T0) and T3' = T3 ^ F1(CON[31:0], T2).
REQ-013 SHALL, for i=1..11, register {T1',T2,T3',T0} as the new {T0,T1,T2,T3} and increment Round.
REQ-014 SHALL, for i=12, register {T0,T1',T2,T3'} with no word rotation, copy the result to L, and enter DONE.
REQ-015 SHALL assert done for exactly the DONE cycle, then return to IDLE; Round=0 in DONE and IDLE.
REQ-016 SHALL have latency of 13 cycles: start sampled at edge N, round i applied at edge N+i, done=1 in the cycle after edge N+12.
REQ-017 SHALL ignore start while in RUN or DONE: no reload and no effect on L.
REQ-018 SHALL accept start in the IDLE cycle immediately following DONE, giving back-to-back operation with one idle cycle.
REQ-019 SHALL leave L unchanged until the final round of the next operation.
REQ-020 SHALL use pure XOR for all word arithmetic: 32-bit, no carries.

Reset
REQ-021 SHALL, when rst=1 at an edge, force IDLE, T0..T3=0, L=0, Round=0, busy=0 and done=0, overriding start.
REQ-022 SHALL abandon any operation on rst mid-RUN with no done pulse; the first post-reset start behaves as from cold.

Configuration
REQ-023 SHALL, with CLEFIA_KS_ABORT_EN defined, add input port abort (1 bit).
REQ-024 SHALL, with CLEFIA_KS_ABORT_EN defined, respond to abort=1 in RUN by returning to IDLE at the next edge, zeroising T0..T3, leaving L unchanged and emitting no done.
REQ-025 SHALL, with CLEFIA_KS_ABORT_EN defined, ignore abort in IDLE and DONE, and give rst priority over abort.
REQ-026 SHALL, without CLEFIA_KS_ABORT_EN, have no abort port and behave only per REQ-010..022.

Structure
REQ-027 SHALL place in the shared CLEFIA package: state encoding, NUM_ROUNDS_128 = 12, and 32-bit word type.
REQ-028 SHALL have one sub-module, clefia_gfn4_round: combinational, inputs T0..T3, RK0, RK1, last; instantiates the existing F0/F1 functions and outputs the next T0..T3.
REQ-029 SHALL instantiate the CON table outside this block and connect it through Round/CON.

Verification
REQ-030 SHALL verify the vector: key=ffeeddcc_bbaa9988_77665544_33221100 with the CON table attached -> L=8f89a61b_9db9d0f3_93e65627_da0d027e, done exactly 13 cycles after start.
REQ-031 SHALL verify the Round sequence: one operation -> Round reads 0,1,2,...,12,0 on consecutive cycles; busy high exactly 12 cycles.
REQ-032 SHALL verify start ignored when busy: start pulses at rounds 3 and 12 with a different key -> L still matches REQ-030, single done.
REQ-033 SHALL verify reset mid-operation: rst at round 6 -> all outputs 0 next cycle, no done; a fresh start then yields the REQ-030 L.
REQ-034 SHALL verify back-to-back operation: a second start with key=0 in the IDLE cycle after done -> second done 14 cycles after the first, L of the first held until that done.
REQ-035 SHALL verify abort (CLEFIA_KS_ABORT_EN defined): abort at round 4 -> IDLE next cycle, no done, L retains its prior value.

Source files
------------

// File: rtl/clefia_ks_gfn12_pkg.sv
// ---------------------------------------------------------------------------
// clefia_ks_gfn12_pkg
// Shared CLEFIA definitions for the 128-bit key schedule:
//   - FSM state encoding, round count, word/state types
//   - S-boxes S0/S1 and the F0/F1 round functions used by GFN4,r
// ---------------------------------------------------------------------------
package clefia_ks_gfn12_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned KEY_W          = 128;
    localparam int unsigned ROUND_W        = 4;
    localparam int unsigned NUM_ROUNDS_128 = 12;

    typedef logic [WORD_W-1:0] word_t;

    // Four-word GFN state; t0 occupies the most significant word.
    typedef struct packed {
        word_t t0;
        word_t t1;
        word_t t2;
        word_t t3;
    } gfn_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // 4-bit S-boxes building S0; leftmost nibble is entry 0, hence the ~x indexing.
    localparam logic [15:0][3:0] SS0 = 64'he6ca872fb14059d3;
    localparam logic [15:0][3:0] SS1 = 64'h640d2ba39cef8751;
    localparam logic [15:0][3:0] SS2 = 64'hb85ea64cf72310d9;
    localparam logic [15:0][3:0] SS3 = 64'ha26d345e0789bfc1;

    // S1 lookup; leftmost byte is entry 0, hence the ~x indexing.
    localparam logic [255:0][7:0] S1_TAB = {
        128'h6cdac3e94e9d0a3db836b43813340cd9,
        128'hbf74948fb79ce5dc9e07494f982cb093,
        128'h12ebcdb392e74160e321273be619d20e,
        128'h9111c73f2a8ea1bc2bc8c50f5bf3878b,
        128'hfbf5de20c6a784ced86551c9a4ef4353,
        128'h255d9b31e83e0dd780ff698aba0b735c,
        128'h6e541562f6353052a316d32832faaa5e,
        128'hcfeaed783358097b63c0c1461edfa999,
        128'h5504c486397782ec4018909759dd831f,
        128'h9a370624647ca556480885d06126ca6f,
        128'h7e6ab671a07005d1458c231cf0ee89ad,
        128'h7a4bc22fdb5a4d7667172df4cbb14aa8,
        128'hb522473ad5104c72cc00f9e0fde2feae,
        128'hf85fabf11b4281d6be4429a657b9aff2,
        128'hd47566bb689f5002013c7f8d1a88bdac,
        128'hf7e47996a2fc6db26b03e12e7d14951d
    };

    // Multiply by 2 in GF(2^4), polynomial z^4+z+1.
    function automatic logic [3:0] gf4_x2(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [7:0] sbox0(input logic [7:0] x);
        logic [3:0] t0, t1, u0, u1;
        t0 = SS0[~x[7:4]];
        t1 = SS1[~x[3:0]];
        u0 = t0 ^ gf4_x2(t1);
        u1 = gf4_x2(t0) ^ t1;
        return {SS2[~u0], SS3[~u1]};
    endfunction

    function automatic logic [7:0] sbox1(input logic [7:0] x);
        return S1_TAB[~x];
    endfunction

    // Multiply by 2 in GF(2^8), polynomial z^8+z^4+z^3+z^2+1.
    function automatic logic [7:0] gf8_x2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
    endfunction

    function automatic logic [7:0] gf8_x4(input logic [7:0] a);
        return gf8_x2(gf8_x2(a));
    endfunction

    function automatic logic [7:0] gf8_x8(input logic [7:0] a);
        return gf8_x2(gf8_x4(a));
    endfunction

    // F0: S0/S1/S0/S1 then M0 = circ-Hadamard(1,2,4,6).
    function automatic word_t f0(input word_t rk, input word_t x);
        word_t      t;
        logic [7:0] y0, y1, y2, y3;
        t  = rk ^ x;
        y0 = sbox0(t[31:24]);
        y1 = sbox1(t[23:16]);
        y2 = sbox0(t[15:8]);
        y3 = sbox1(t[7:0]);
        return {y0 ^ gf8_x2(y1) ^ gf8_x4(y2) ^ gf8_x4(y3) ^ gf8_x2(y3),
                gf8_x2(y0) ^ y1 ^ gf8_x4(y2) ^ gf8_x2(y2) ^ gf8_x4(y3),
                gf8_x4(y0) ^ gf8_x4(y1) ^ gf8_x2(y1) ^ y2 ^ gf8_x2(y3),
                gf8_x4(y0) ^ gf8_x2(y0) ^ gf8_x4(y1) ^ gf8_x2(y2) ^ y3};
    endfunction

    // F1: S1/S0/S1/S0 then M1 = circ-Hadamard(1,8,2,a).
    function automatic word_t f1(input word_t rk, input word_t x);
        word_t      t;
        logic [7:0] y0, y1, y2, y3;
        t  = rk ^ x;
        y0 = sbox1(t[31:24]);
        y1 = sbox0(t[23:16]);
        y2 = sbox1(t[15:8]);
        y3 = sbox0(t[7:0]);
        return {y0 ^ gf8_x8(y1) ^ gf8_x2(y2) ^ gf8_x8(y3) ^ gf8_x2(y3),
                gf8_x8(y0) ^ y1 ^ gf8_x8(y2) ^ gf8_x2(y2) ^ gf8_x2(y3),
                gf8_x2(y0) ^ gf8_x8(y1) ^ gf8_x2(y1) ^ y2 ^ gf8_x8(y3),
                gf8_x8(y0) ^ gf8_x2(y0) ^ gf8_x2(y1) ^ gf8_x8(y2) ^ y3};
    endfunction

endpackage

// File: rtl/clefia_gfn4_round.sv
// ---------------------------------------------------------------------------
// clefia_gfn4_round
// One combinational round of the 4-branch generalized Feistel network.
//   t_i    : current state {T0,T1,T2,T3}
//   rk0_i  : round key fed to F0 (applied to T0, mixed into T1)
//   rk1_i  : round key fed to F1 (applied to T2, mixed into T3)
//   last_i : final round, suppresses the word rotation
//   t_c_o  : next state (combinational)
// ---------------------------------------------------------------------------
module clefia_gfn4_round
    import clefia_ks_gfn12_pkg::*;
(
    input  gfn_state_t t_i,
    input  word_t      rk0_i,
    input  word_t      rk1_i,
    input  logic       last_i,
    output gfn_state_t t_c_o
);

    word_t t1_n;
    word_t t3_n;

    assign t1_n = t_i.t1 ^ f0(rk0_i, t_i.t0);
    assign t3_n = t_i.t3 ^ f1(rk1_i, t_i.t2);

    // Rotate left by one word except after the last round.
    assign t_c_o = last_i ? {t_i.t0, t1_n, t_i.t2, t3_n}
                          : {t1_n, t_i.t2, t3_n, t_i.t0};

endmodule

// File: rtl/clefia_ks_gfn12.sv
// ---------------------------------------------------------------------------
// clefia_ks_gfn12
// CLEFIA-128 key schedule front half: L = GFN4,12(CON0..23, K), one round
// per clock. The constant table lives outside; this block drives Round and
// consumes the matching CON pair combinationally.
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin an operation (accepted in IDLE only), key sampled with it
//   key       : K, key[127:96] = T0 ... key[31:0] = T3
//   Round     : 1..12 while running, 0 otherwise
//   CON       : {CON_(2i-2), CON_(2i-1)} for the current Round
//   busy      : high while rounds are being applied
//   done      : one-cycle pulse when L is valid
//   L         : result, held until the final round of the next operation
//   abort     : present only with CLEFIA_KS_ABORT_EN; abandons a running
//               operation, clears the working state, keeps L
// ---------------------------------------------------------------------------
module clefia_ks_gfn12
    import clefia_ks_gfn12_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef CLEFIA_KS_ABORT_EN
    input  logic               abort,
`endif
    input  logic [KEY_W-1:0]   key,
    output logic [ROUND_W-1:0] Round,
    input  logic [63:0]        CON,
    output logic               busy,
    output logic               done,
    output logic [KEY_W-1:0]   L
);

    state_e             state_q, state_d;
    gfn_state_t         t_q, t_d;
    gfn_state_t         t_rnd;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [KEY_W-1:0]   l_q, l_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               last_c;

    assign last_c = (round_q == ROUND_W'(NUM_ROUNDS_128));

    clefia_gfn4_round u_round (
        .t_i    (t_q),
        .rk0_i  (CON[63:32]),
        .rk1_i  (CON[31:0]),
        .last_i (last_c),
        .t_c_o  (t_rnd)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            round_q <= '0;
            l_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            round_q <= round_d;
            l_q     <= l_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        round_d = '0;
        l_d     = l_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    t_d     = gfn_state_t'(key);
                    round_d = ROUND_W'(1);
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                t_d = t_rnd;
                if (last_c) begin
                    l_d     = KEY_W'(t_rnd);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    round_d = round_q + ROUND_W'(1);
                    busy_d  = 1'b1;
                end
`ifdef CLEFIA_KS_ABORT_EN
                // Abort wins over the round update; L is left untouched.
                if (abort) begin
                    t_d     = '0;
                    l_d     = l_q;
                    round_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
`endif
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Round = round_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign L     = l_q;

endmodule

// File: tb/tb_clefia_ks_gfn12.sv
// ---------------------------------------------------------------------------
// tb_clefia_ks_gfn12
// Bench for the CLEFIA-128 key-schedule GFN. Provides the CON table from
// Round, keeps an operation-level model of Round/busy/done/L, and runs
// directed scenarios: reference vector, Round sequence, ignored starts,
// mid-run reset, back-to-back operation and (with CLEFIA_KS_ABORT_EN) abort.
// ---------------------------------------------------------------------------
module tb_clefia_ks_gfn12;
    import clefia_ks_gfn12_pkg::*;

    localparam logic [127:0] K_VEC = 128'hffeeddcc_bbaa9988_77665544_33221100;
    localparam logic [127:0] L_VEC = 128'h8f89a61b_9db9d0f3_93e65627_da0d027e;
    localparam logic [127:0] K_ALT = 128'h01234567_89abcdef_fedcba98_76543210;

    localparam logic [7:0] M0 [4][4] = '{'{8'h01, 8'h02, 8'h04, 8'h06},
                                        '{8'h02, 8'h01, 8'h06, 8'h04},
                                        '{8'h04, 8'h06, 8'h01, 8'h02},
                                        '{8'h06, 8'h04, 8'h02, 8'h01}};
    localparam logic [7:0] M1 [4][4] = '{'{8'h01, 8'h08, 8'h02, 8'h0a},
                                        '{8'h08, 8'h01, 8'h0a, 8'h02},
                                        '{8'h02, 8'h0a, 8'h01, 8'h08},
                                        '{8'h0a, 8'h02, 8'h08, 8'h01}};

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [3:0]   Round;
    logic [63:0]  CON;
    logic         busy;
    logic         done;
    logic [127:0] L;
`ifdef CLEFIA_KS_ABORT_EN
    logic         abort;
`endif

    clefia_ks_gfn12 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef CLEFIA_KS_ABORT_EN
        .abort (abort),
`endif
        .key   (key),
        .Round (Round),
        .CON   (CON),
        .busy  (busy),
        .done  (done),
        .L     (L)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // ---------------- CON table (generated from the CLEFIA-128 rule) -------
    logic [31:0] con_tab [24];

    task automatic build_con();
        logic [15:0] t;
        logic [15:0] nt;
        t = 16'h428a;
        for (int i = 0; i < 12; i++) begin
            nt = ~t;
            con_tab[2*i]   = {t ^ 16'hb7e1, nt[14:0], nt[15]};
            con_tab[2*i+1] = {nt ^ 16'h243f, t[7:0], t[15:8]};
            // multiply by z^-1 modulo z^16+z^15+z^13+z^11+z^5+z^4+1
            if (t[0]) t = ((t ^ 16'ha831) >> 1) | 16'h8000;
            else      t = t >> 1;
        end
    endtask

    always_comb begin
        CON = 64'h0;
        if (Round >= 4'd1 && Round <= 4'd12)
            CON = {con_tab[2*int'(Round)-2], con_tab[2*int'(Round)-1]};
    end

    // ---------------- reference model ---------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1d : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] ffun(input bit is_f1, input logic [31:0] rk, input logic [31:0] x);
        logic [31:0] t, r;
        logic [7:0]  y [4];
        logic [7:0]  b, acc;
        t = rk ^ x;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            b = t[31-8*j -: 8];
            y[j] = (((j % 2) == 0) != is_f1) ? sbox0(b) : sbox1(b);
        end
        for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
                acc = acc ^ gmul(is_f1 ? M1[i][j] : M0[i][j], y[j]);
            r[31-8*i -: 8] = acc;
        end
        return r;
    endfunction

    function automatic logic [127:0] gfn_model(input logic [127:0] k);
        logic [31:0] w [4];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int r = 0; r < 12; r++) begin
            w[1] = w[1] ^ ffun(1'b0, con_tab[2*r],   w[0]);
            w[3] = w[3] ^ ffun(1'b1, con_tab[2*r+1], w[2]);
            if (r < 11) begin
                tmp = w[0]; w[0] = w[1]; w[1] = w[2]; w[2] = w[3]; w[3] = tmp;
            end
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // Operation age: 0 idle, 1..12 = round in flight, 13 = done cycle.
    int           age   = 0;
    logic [127:0] exp_L = '0;
    logic [127:0] cur_key = '0;

    always @(posedge clk) begin
        if (rst) begin
            age   <= 0;
            exp_L <= '0;
        end else if (age == 0) begin
            if (start) begin
                age     <= 1;
                cur_key <= key;
            end
        end else if (age <= 12) begin
`ifdef CLEFIA_KS_ABORT_EN
            if (abort) age <= 0;
            else
`endif
            begin
                if (age == 12) exp_L <= gfn_model(cur_key);
                age <= age + 1;
            end
        end else begin
            age <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_round", 128'(Round), 128'((age >= 1 && age <= 12) ? age : 0));
            check("cyc_busy",  128'(busy),  128'(age >= 1 && age <= 12));
            check("cyc_done",  128'(done),  128'(age == 13));
            check("cyc_L",     L,           exp_L);
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int seq [14];
        int first_done, bcnt, dcnt, d2;
        bit hit;

        build_con();
        rst = 1'b1; start = 1'b0; key = '0;
`ifdef CLEFIA_KS_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // model pins
        check("con0",      128'(con_tab[0]),  128'(32'hf56b7aeb));
        check("con23",     128'(con_tab[23]), 128'(32'he4ed2d3f));
        check("model_vec", gfn_model(K_VEC),  L_VEC);

        // reset state
        check("rst_round", 128'(Round), 128'(0));
        check("rst_busy",  128'(busy),  128'(0));
        check("rst_done",  128'(done),  128'(0));
        check("rst_L",     L,           128'(0));

        // reference vector, latency and Round sequence
        seq[0] = int'(Round);
        start = 1'b1; key = K_VEC;
        first_done = -1; bcnt = 0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            start = 1'b0; key = K_ALT;
            seq[k] = int'(Round);
            bcnt += int'(busy);
            if (done && first_done < 0) first_done = k;
        end
        check("latency", 128'(first_done), 128'(13));
        for (int k = 0; k <= 13; k++)
            check("round_seq", 128'(seq[k]), 128'((k >= 1 && k <= 12) ? k : 0));
        check("busy_cycles", 128'(bcnt), 128'(12));
        check("vec_L", L, L_VEC);
        tick();
        check("done_pulse", 128'(done), 128'(0));

        // starts while busy are ignored
        start = 1'b1; key = K_VEC; dcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            start = 1'b0; key = K_VEC;
            if (done) dcnt++;
            if (Round == 4'd3 || Round == 4'd12) begin
                start = 1'b1; key = K_ALT;
            end
        end
        start = 1'b0;
        check("ign_done_cnt", 128'(dcnt), 128'(1));
        check("ign_L", L, L_VEC);

        // reset in the middle of an operation
        start = 1'b1; key = K_VEC; hit = 1'b0;
        for (int k = 1; k <= 20 && !hit; k++) begin
            tick();
            start = 1'b0;
            if (Round == 4'd6) hit = 1'b1;
        end
        check("reach_round6", 128'(hit), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_round", 128'(Round), 128'(0));
        check("mid_rst_busy",  128'(busy),  128'(0));
        check("mid_rst_done",  128'(done),  128'(0));
        check("mid_rst_L",     L,           128'(0));
        dcnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (done) dcnt++;
        end
        check("mid_rst_no_done", 128'(dcnt), 128'(0));
        start = 1'b1; key = K_VEC; first_done = -1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            start = 1'b0;
            if (done && first_done < 0) first_done = k;
        end
        check("cold_latency", 128'(first_done), 128'(13));
        check("cold_L", L, L_VEC);

        // back-to-back: second start in the idle cycle after done
        tick();
        start = 1'b1; key = K_VEC; first_done = -1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            start = 1'b0;
            if (done && first_done < 0) first_done = k;
        end
        check("b2b_first", 128'(first_done), 128'(13));
        tick();
        start = 1'b1; key = '0; d2 = -1;
        for (int k = 2; k <= 20 && d2 < 0; k++) begin
            tick();
            start = 1'b0; key = K_ALT;
            if (done) d2 = k;
            else      check("b2b_L_held", L, L_VEC);
        end
        check("b2b_gap", 128'(d2), 128'(14));
        check("b2b_L2", L, gfn_model(128'h0));

`ifdef CLEFIA_KS_ABORT_EN
        // abort mid-run keeps the previous L and emits no done
        tick();
        start = 1'b1; key = K_VEC; hit = 1'b0;
        for (int k = 1; k <= 20 && !hit; k++) begin
            tick();
            start = 1'b0;
            if (Round == 4'd4) hit = 1'b1;
        end
        check("reach_round4", 128'(hit), 128'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy",  128'(busy),  128'(0));
        check("abort_round", 128'(Round), 128'(0));
        check("abort_L",     L,           gfn_model(128'h0));
        dcnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (done) dcnt++;
        end
        check("abort_no_done", 128'(dcnt), 128'(0));
        // abort in IDLE does not block a start
        start = 1'b1; abort = 1'b1; key = K_VEC;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_idle_ign", 128'(busy), 128'(1));
        repeat (14) tick();
        check("abort_idle_L", L, L_VEC);
`endif

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
